// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Feeds the serial input of the downstream Moore sequence detector.
//   Parallel words arrive over a valid/ready handshake into a one-word
//   holding buffer, then leave one bit per enabled clock from a shift
//   register. Back-to-back words are emitted with no bubble bit.
//
// Parameters
//   WIDTH      word width in bits (1..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   in_data   parallel word to serialize
//   in_valid  in_data is valid
//   in_ready  buffer can accept a word (~buf_full & ~reset)
//   shift_en  advance enable; 0 freezes everything but the input handshake
//   x         serial bit (registered)
//   x_valid   x carries a real data bit (registered)
//   last_bit  x holds the final bit of a word (registered)
//   busy      a word is being shifted or is waiting in the buffer
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             drain;

  // Bit that leaves the word next, according to the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its head bit consumed; the following bit moves to the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // in_ready looks only at buf_full: a full buffer refuses input even on
  // the edge it drains, so accept and drain are mutually exclusive.
  assign in_ready = ~buf_full & ~reset;
  assign accept   = in_valid & in_ready;
  assign drain    = shift_en & buf_full & ((state == IDLE) | (cnt == '0));
  assign busy     = (state == SHIFT) | buf_full;

  // Holding buffer payload; only meaningful while buf_full is set.
  always_ff @(posedge clk) begin
    if (accept) buf_data <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      x        <= 1'b0;
      x_valid  <= 1'b0;
      last_bit <= 1'b0;
    end else begin
      if (accept)     buf_full <= 1'b1;
      else if (drain) buf_full <= 1'b0;

      if (shift_en) begin
        if (drain) begin
          // Load from IDLE or reload at word end: first bit goes straight
          // to x so the stream has no gap between words.
          state    <= SHIFT;
          shreg    <= advance(buf_data);
          x        <= head_bit(buf_data);
          x_valid  <= 1'b1;
          last_bit <= (WIDTH == 1);
          cnt      <= CNT_LAST;
        end else if (state == SHIFT && cnt != '0) begin
          shreg    <= advance(shreg);
          x        <= head_bit(shreg);
          cnt      <= cnt - 1'b1;
          last_bit <= (cnt == CNT_W'(1));
        end else if (state == SHIFT) begin
          state    <= IDLE;
          x        <= 1'b0;
          x_valid  <= 1'b0;
          last_bit <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: two instances (WIDTH=4 MSB-first and
// WIDTH=8 LSB-first), directed scenarios followed by randomized traffic
// checked against a bit-stream queue model.
module tb_serial_bit_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MSB first
  logic       a_reset, a_in_valid, a_in_ready, a_shift_en;
  logic [3:0] a_in_data;
  logic       a_x, a_x_valid, a_last_bit, a_busy;

  // Instance B: WIDTH=8, LSB first
  logic       b_reset, b_in_valid, b_in_ready, b_shift_en;
  logic [7:0] b_in_data;
  logic       b_x, b_x_valid, b_last_bit, b_busy;

  serial_bit_source #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .shift_en(a_shift_en), .x(a_x),
    .x_valid(a_x_valid), .last_bit(a_last_bit), .busy(a_busy));

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .shift_en(b_shift_en), .x(b_x),
    .x_valid(b_x_valid), .last_bit(b_last_bit), .busy(b_busy));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic b;
    logic l;
  } sbit_t;
  sbit_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp8;
  logic [7:0] exp_b2b;
  int         nvalid;
  logic       acc, en_s;
  sbit_t      e;

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b1; a_in_data = 4'hF; a_shift_en = 1'b1;
    b_reset = 1'b1; b_in_valid = 1'b1; b_in_data = 8'hFF; b_shift_en = 1'b1;
    #1;
    chk("reset_ready_t0", 32'(a_in_ready), 32'd0);

    // Reset held two cycles with a word offered
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_x", 32'(a_x), 32'd0);
      chk("reset_xvalid", 32'(a_x_valid), 32'd0);
      chk("reset_ready", 32'(a_in_ready), 32'd0);
      chk("reset_b_ready", 32'(b_in_ready), 32'd0);
    end
    a_reset = 1'b0; a_in_valid = 1'b0;
    b_reset = 1'b0; b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_xvalid", 32'(a_x_valid), 32'd0);
    end
    chk("post_reset_busy", 32'(a_busy), 32'd0);
    chk("post_reset_ready", 32'(a_in_ready), 32'd1);

    // Single word 0011 on WIDTH=4 MSB-first
    a_in_valid = 1'b1; a_in_data = 4'b0011;
    tick();  // edge N: accepted
    a_in_valid = 1'b0;
    chk("single_idle_xvalid", 32'(a_x_valid), 32'd0);
    chk("single_busy", 32'(a_busy), 32'd1);
    exp8 = 8'b0000_0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_xvalid", 32'(a_x_valid), 32'd1);
      chk("single_x", 32'(a_x), 32'(exp8[3-i]));
      chk("single_last", 32'(a_last_bit), 32'(i == 3));
    end
    tick();
    chk("single_end_xvalid", 32'(a_x_valid), 32'd0);
    chk("single_end_busy", 32'(a_busy), 32'd0);

    // Back-to-back 0011 then 1111
    exp_b2b = 8'b0011_1111;
    a_in_valid = 1'b1; a_in_data = 4'b0011;
    tick();  // edge N
    a_in_data = 4'b1111;
    chk("b2b_ready_full", 32'(a_in_ready), 32'd0);
    tick();  // edge N+1: not accepted, first bit out
    chk("b2b_x0", 32'(a_x), 32'(exp_b2b[7]));
    chk("b2b_ready_free", 32'(a_in_ready), 32'd1);
    tick();  // edge N+2: second word accepted
    a_in_valid = 1'b0;
    chk("b2b_x1", 32'(a_x), 32'(exp_b2b[6]));
    chk("b2b_ready_k1", 32'(a_in_ready), 32'd0);
    for (int k = 2; k < 8; k++) begin
      tick();
      chk("b2b_xvalid", 32'(a_x_valid), 32'd1);
      chk("b2b_x", 32'(a_x), 32'(exp_b2b[7-k]));
      chk("b2b_last", 32'(a_last_bit), 32'(k == 3 || k == 7));
      chk("b2b_ready", 32'(a_in_ready), 32'(k >= 4));
    end
    tick();
    chk("b2b_end_xvalid", 32'(a_x_valid), 32'd0);

    // Stall: 1010 with shift_en low for 3 cycles after the second bit
    nvalid = 0;
    a_in_valid = 1'b1; a_in_data = 4'b1010;
    tick();
    a_in_valid = 1'b0;
    tick(); nvalid += int'(a_x_valid);
    chk("stall_b0", 32'(a_x), 32'd1);
    tick(); nvalid += int'(a_x_valid);
    chk("stall_b1", 32'(a_x), 32'd0);
    a_shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); nvalid += int'(a_x_valid);
      chk("stall_hold_x", 32'(a_x), 32'd0);
      chk("stall_hold_last", 32'(a_last_bit), 32'd0);
    end
    a_shift_en = 1'b1;
    tick(); nvalid += int'(a_x_valid);
    chk("stall_b2", 32'(a_x), 32'd1);
    tick(); nvalid += int'(a_x_valid);
    chk("stall_b3", 32'(a_x), 32'd0);
    chk("stall_b3_last", 32'(a_last_bit), 32'd1);
    tick(); nvalid += int'(a_x_valid);
    chk("stall_valid_cycles", 32'(nvalid), 32'd7);

    // LSB-first 8'h0D on WIDTH=8
    b_in_valid = 1'b1; b_in_data = 8'h0D;
    tick();
    b_in_valid = 1'b0;
    exp8 = 8'h0D;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lsb_xvalid", 32'(b_x_valid), 32'd1);
      chk("lsb_x", 32'(b_x), 32'(exp8[i]));
      chk("lsb_last", 32'(b_last_bit), 32'(i == 7));
    end
    tick();
    chk("lsb_end_xvalid", 32'(b_x_valid), 32'd0);

    // Reset mid-word: F0 shifting, 0F buffered, reset while bit 3 is on x
    b_in_valid = 1'b1; b_in_data = 8'hF0;
    tick();  // N: F0 accepted
    b_in_data = 8'h0F;
    tick();  // N+1: F0 loads
    tick();  // N+2: 0F accepted
    b_in_valid = 1'b0;
    chk("midrst_busy", 32'(b_busy), 32'd1);
    tick();  // N+3
    tick();  // N+4: bit 3 on x
    chk("midrst_bit3_valid", 32'(b_x_valid), 32'd1);
    b_reset = 1'b1;
    tick();
    chk("midrst_xvalid", 32'(b_x_valid), 32'd0);
    chk("midrst_x", 32'(b_x), 32'd0);
    chk("midrst_last", 32'(b_last_bit), 32'd0);
    chk("midrst_busy_clr", 32'(b_busy), 32'd0);
    b_reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(b_in_ready), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      nvalid += int'(b_x_valid);
    end
    chk("midrst_no_emit", 32'(nvalid), 32'd0);

    // Randomized traffic on instance A against a bit-stream queue
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 500) begin
        a_in_valid = 1'($urandom_range(0, 1));
        a_in_data  = 4'($urandom);
        a_shift_en = ($urandom_range(0, 3) != 0);
      end else begin
        a_in_valid = 1'b0;
        a_shift_en = 1'b1;
      end
      #1;
      acc  = a_in_valid & a_in_ready;
      en_s = a_shift_en;
      if (acc)
        for (int i = 3; i >= 0; i--) q.push_back('{b: a_in_data[i], l: (i == 0)});
      tick();
      if (en_s && a_x_valid) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rand_x", 32'(a_x), 32'(e.b));
          chk("rand_last", 32'(a_last_bit), 32'(e.l));
        end
      end
    end
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_idle", 32'(a_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
